cfu_l2_arb: RTL and testbench



---
 rtl/cfu_l2_arb_if.sv | 45 ++++
 rtl/cfu_l2_arb.sv | 134 +++++++++++++
 tb/tb_cfu_l2_arb.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfu_l2_arb_if.sv
// Bundle of requester-side and target-side CFU-L2 handshake signals for cfu_l2_arb.
// slave is the arbiter's view; master is the view of the requesters plus shared target.
interface cfu_l2_arb_if #(
   parameter int N_REQ         = 2,
   parameter int CFU_CFU_ID_W  = 4,
   parameter int CFU_FUNC_ID_W = 10,
   parameter int CFU_DATA_W    = 32,
   parameter int CFU_STATUS_W  = 3
);
   logic [N_REQ-1:0]               req_valid;
   logic [N_REQ-1:0]               req_ready;
   logic [N_REQ*CFU_CFU_ID_W-1:0]  req_cfu;
   logic [N_REQ*CFU_FUNC_ID_W-1:0] req_func;
   logic [N_REQ*CFU_DATA_W-1:0]    req_data0;
   logic [N_REQ*CFU_DATA_W-1:0]    req_data1;
   logic [N_REQ-1:0]               resp_valid;
   logic [N_REQ-1:0]               resp_ready;
   logic [CFU_STATUS_W-1:0]        resp_status;
   logic [CFU_DATA_W-1:0]          resp_data;

   logic                           t_req_valid;
   logic                           t_req_ready;
   logic [CFU_CFU_ID_W-1:0]        t_req_cfu;
   logic [CFU_FUNC_ID_W-1:0]       t_req_func;
   logic [CFU_DATA_W-1:0]          t_req_data0;
   logic [CFU_DATA_W-1:0]          t_req_data1;
   logic                           t_resp_valid;
   logic                           t_resp_ready;
   logic [CFU_STATUS_W-1:0]        t_resp_status;
   logic [CFU_DATA_W-1:0]          t_resp_data;

   modport slave (
      input  req_valid, req_cfu, req_func, req_data0, req_data1, resp_ready,
      input  t_req_ready, t_resp_valid, t_resp_status, t_resp_data,
      output req_ready, resp_valid, resp_status, resp_data,
      output t_req_valid, t_req_cfu, t_req_func, t_req_data0, t_req_data1, t_resp_ready
   );

   modport master (
      output req_valid, req_cfu, req_func, req_data0, req_data1, resp_ready,
      output t_req_ready, t_resp_valid, t_resp_status, t_resp_data,
      input  req_ready, resp_valid, resp_status, resp_data,
      input  t_req_valid, t_req_cfu, t_req_func, t_req_data0, t_req_data1, t_resp_ready
   );
endinterface

// File: rtl/cfu_l2_arb.sv
// Round-robin arbiter sharing one CFU-L2 target among N_REQ requesters; an in-order
// ID FIFO steers each target response back to the requester that issued it.
module cfu_l2_arb #(
   parameter int N_REQ         = 2,
   parameter int CFU_CFU_ID_W  = 4,
   parameter int CFU_FUNC_ID_W = 10,
   parameter int CFU_DATA_W    = 32,
   parameter int CFU_STATUS_W  = 3,
   parameter int DEPTH         = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clk_en,
   cfu_l2_arb_if.slave  bus,
   output logic         err
);
   localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  gnt;
   logic [ID_W-1:0]  cand;
   logic [ID_W-1:0]  lock_id;
   logic [ID_W-1:0]  head;
   logic             lock;
   logic             any;
   logic             full;
   logic             nonempty;
   logic             t_req_valid;
   logic             t_resp_ready;
   logic             push;
   logic             pop;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [ID_W-1:0]  fifo [DEPTH];
   logic [N_REQ-1:0] req_ready;
   logic [N_REQ-1:0] resp_valid;

   logic [CFU_CFU_ID_W-1:0]  cfu_a   [N_REQ];
   logic [CFU_FUNC_ID_W-1:0] func_a  [N_REQ];
   logic [CFU_DATA_W-1:0]    data0_a [N_REQ];
   logic [CFU_DATA_W-1:0]    data1_a [N_REQ];

   function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [ID_W-1:0] next_rr(input logic [ID_W-1:0] g);
      return (g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1;
   endfunction

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign cfu_a[i]   = bus.req_cfu[i*CFU_CFU_ID_W +: CFU_CFU_ID_W];
      assign func_a[i]  = bus.req_func[i*CFU_FUNC_ID_W +: CFU_FUNC_ID_W];
      assign data0_a[i] = bus.req_data0[i*CFU_DATA_W +: CFU_DATA_W];
      assign data1_a[i] = bus.req_data1[i*CFU_DATA_W +: CFU_DATA_W];
   end

   // Search downward from the farthest candidate so the nearest one after ptr wins.
   always_comb begin
      gnt  = ptr;
      cand = '0;
      if (lock) begin
         gnt = lock_id;
      end else begin
         for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (bus.req_valid[cand]) gnt = cand;
         end
      end
   end

   assign any      = lock || (|bus.req_valid);
   assign full     = (count == CNT_W'(DEPTH));
   assign nonempty = (count != '0);
   assign head     = fifo[rd_ptr];

   // rst_n gate keeps the target idle while reset is held, even with requests pending.
   assign t_req_valid  = any && !full && clk_en && rst_n;
   assign t_resp_ready = nonempty && bus.resp_ready[head] && clk_en;
   assign push         = t_req_valid && bus.t_req_ready;
   assign pop          = bus.t_resp_valid && t_resp_ready;

   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      if (push) req_ready[gnt] = 1'b1;
      if (bus.t_resp_valid && nonempty) resp_valid[head] = 1'b1;
   end

   assign bus.req_ready    = req_ready;
   assign bus.resp_valid   = resp_valid;
   assign bus.resp_status  = bus.t_resp_status;
   assign bus.resp_data    = bus.t_resp_data;
   assign bus.t_req_valid  = t_req_valid;
   assign bus.t_req_cfu    = cfu_a[gnt];
   assign bus.t_req_func   = func_a[gnt];
   assign bus.t_req_data0  = data0_a[gnt];
   assign bus.t_req_data1  = data1_a[gnt];
   assign bus.t_resp_ready = t_resp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr    <= '0;
         lock   <= 1'b0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         err    <= 1'b0;
      end else if (clk_en) begin
         if (push) begin
            ptr    <= next_rr(gnt);
            lock   <= 1'b0;
            wr_ptr <= inc_ptr(wr_ptr);
         end else if (t_req_valid) begin
            lock <= 1'b1;
         end
         if (pop) rd_ptr <= inc_ptr(rd_ptr);
         if (push && !pop) count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
         if (bus.t_resp_valid && !nonempty) err <= 1'b1;
      end
   end

   // Payload registers: only meaningful once qualified by count / lock.
   always_ff @(posedge clk) begin
      if (clk_en) begin
         if (push) fifo[wr_ptr] <= gnt;
         if (t_req_valid && !bus.t_req_ready) lock_id <= gnt;
      end
   end
endmodule

// File: tb/tb_cfu_l2_arb.sv
// Scenario bench for cfu_l2_arb: expected grant/response order is queued as stimulus
// is applied and compared against what the arbiter accepts and routes back.
module tb_cfu_l2_arb;
   localparam int N  = 2;
   localparam int DW = 32;

   logic clk;
   logic rst_n;
   logic clk_en;
   logic err;

   cfu_l2_arb_if #(.N_REQ(N), .CFU_CFU_ID_W(4), .CFU_FUNC_ID_W(10),
                   .CFU_DATA_W(DW), .CFU_STATUS_W(3)) bus ();

   cfu_l2_arb #(.N_REQ(N), .CFU_CFU_ID_W(4), .CFU_FUNC_ID_W(10), .CFU_DATA_W(DW),
                .CFU_STATUS_W(3), .DEPTH(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .bus    (bus),
      .err    (err)
   );

   typedef struct {int id; logic [DW-1:0] data;} exp_t;
   typedef struct packed {logic [N-1:0] vld; logic [DW-1:0] data;} rsp_t;

   exp_t           exp_q[$];
   logic [N-1:0]   acc_log[$];
   rsp_t           rsp_log[$];
   logic [DW-1:0]  tgt_q[$];
   bit             auto_resp;
   int             total = 0;
   int             bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, wanted finish");
      $fatal(1);
   end

   task automatic set_req(input int i, input logic [3:0] c, input logic [9:0] f,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      bus.req_cfu[i*4 +: 4]     = c;
      bus.req_func[i*10 +: 10]  = f;
      bus.req_data0[i*DW +: DW] = d0;
      bus.req_data1[i*DW +: DW] = d1;
   endtask

   // Records handshakes seen this cycle; the target model returns data0+data1.
   task automatic tick(input bit at_neg);
      if (!at_neg) @(negedge clk);
      if (bus.t_resp_valid && bus.t_resp_ready) begin
         rsp_log.push_back('{vld: bus.resp_valid, data: bus.resp_data});
         void'(tgt_q.pop_front());
      end
      if (bus.t_req_valid && bus.t_req_ready) begin
         acc_log.push_back(bus.req_ready);
         tgt_q.push_back(bus.t_req_data0 + bus.t_req_data1);
      end
      @(posedge clk);
      #1;
      if (auto_resp) begin
         bus.t_resp_valid = (tgt_q.size() > 0);
         bus.t_resp_data  = (tgt_q.size() > 0) ? tgt_q[0] : '0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clk_en = 1'b1;
      auto_resp = 1'b0;
      bus.req_valid = '0;
      bus.resp_ready = '1;
      bus.t_req_ready = 1'b0;
      bus.t_resp_valid = 1'b0;
      bus.t_resp_status = '0;
      bus.t_resp_data = '0;
      set_req(0, 4'd1, 10'd3, 32'd5, 32'd7);
      set_req(1, 4'd2, 10'd9, 32'd200, 32'd2);
      exp_q.delete();
      acc_log.delete();
      rsp_log.delete();
      tgt_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      bus.req_valid = 2'b11;
      bus.t_req_ready = 1'b1;
      bus.t_resp_valid = 1'b1;
      @(negedge clk);
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", bus.req_ready); end
      total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid got=%b want=00", bus.resp_valid); end
      total++; if (bus.t_req_valid !== 1'b0) begin bad++; $display("FAIL reset_t_req_valid got=%b want=0", bus.t_req_valid); end
      total++; if (bus.t_resp_ready !== 1'b0) begin bad++; $display("FAIL reset_t_resp_ready got=%b want=0", bus.t_resp_ready); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
   endtask

   task automatic test_single();
      do_reset();
      bus.req_valid = 2'b01;
      bus.t_req_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_req_ready got=%b want=01", bus.req_ready); end
      total++; if ({bus.t_req_cfu, bus.t_req_func, bus.t_req_data0, bus.t_req_data1} !== {4'd1, 10'd3, 32'd5, 32'd7})
         begin bad++; $display("FAIL single_fields got=%0d/%0d/%0d/%0d want=1/3/5/7", bus.t_req_cfu, bus.t_req_func, bus.t_req_data0, bus.t_req_data1); end
      tick(1'b1);
      bus.req_valid = 2'b00;
      bus.t_resp_valid = 1'b1;
      bus.t_resp_data = 32'd12;
      @(negedge clk);
      total++; if (bus.resp_valid !== 2'b01) begin bad++; $display("FAIL single_resp_valid got=%b want=01", bus.resp_valid); end
      total++; if (bus.resp_data !== 32'd12 || bus.resp_status !== 3'd0)
         begin bad++; $display("FAIL single_resp_data got=%0d st=%0d want=12 st=0", bus.resp_data, bus.resp_status); end
      total++; if (bus.t_resp_ready !== 1'b1) begin bad++; $display("FAIL single_t_resp_ready got=%b want=1", bus.t_resp_ready); end
      tick(1'b1);
      bus.t_resp_valid = 1'b0;
      total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL single_count got=%0d want=0", dut.count); end
   endtask

   task automatic test_fairness();
      exp_t e;
      logic [N-1:0] oh;
      int guard;
      do_reset();
      auto_resp = 1'b1;
      bus.t_req_ready = 1'b1;
      bus.req_valid = 2'b11;
      for (int k = 0; k < 6; k++) exp_q.push_back('{id: k % 2, data: (k % 2) ? 32'd202 : 32'd12});
      repeat (6) tick(1'b0);
      bus.req_valid = 2'b00;
      guard = 0;
      while (rsp_log.size() < 6 && guard < 20) begin tick(1'b0); guard++; end
      total++; if (acc_log.size() != 6 || rsp_log.size() != 6)
         begin bad++; $display("FAIL fair_counts got acc=%0d rsp=%0d want=6/6", acc_log.size(), rsp_log.size()); end
      for (int k = 0; exp_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         oh = '0;
         oh[e.id] = 1'b1;
         total++; if (k >= acc_log.size() || acc_log[k] !== oh)
            begin bad++; $display("FAIL fair_grant[%0d] got=%b want=%b", k, (k < acc_log.size()) ? acc_log[k] : 2'bxx, oh); end
         total++; if (k >= rsp_log.size() || rsp_log[k] !== {oh, e.data})
            begin bad++; $display("FAIL fair_resp[%0d] got=%h want=%h", k, (k < rsp_log.size()) ? rsp_log[k] : 34'hx, {oh, e.data}); end
      end
   endtask

   task automatic test_lock();
      do_reset();
      // Prime ptr to 1 so an unlocked arbiter would switch to requester 1.
      auto_resp = 1'b1;
      bus.t_req_ready = 1'b1;
      bus.req_valid = 2'b01;
      tick(1'b0);
      bus.req_valid = 2'b00;
      repeat (2) tick(1'b0);
      auto_resp = 1'b0;
      bus.t_resp_valid = 1'b0;
      set_req(0, 4'd1, 10'd4, 32'h11, 32'h22);
      bus.t_req_ready = 1'b0;
      bus.req_valid = 2'b01;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) bus.req_valid = 2'b11;
         @(negedge clk);
         total++; if (bus.t_req_valid !== 1'b1 || bus.t_req_data0 !== 32'h11 || bus.t_req_func !== 10'd4)
            begin bad++; $display("FAIL lock_hold[%0d] got v=%b d0=%h f=%0d want v=1 d0=11 f=4", c, bus.t_req_valid, bus.t_req_data0, bus.t_req_func); end
         total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL lock_ready[%0d] got=%b want=00", c, bus.req_ready); end
         tick(1'b1);
      end
      bus.t_req_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.req_ready !== 2'b01 || bus.t_req_data0 !== 32'h11)
         begin bad++; $display("FAIL lock_accept got=%b d0=%h want=01 d0=11", bus.req_ready, bus.t_req_data0); end
      tick(1'b1);
      bus.req_valid = 2'b10;
      @(negedge clk);
      total++; if (bus.req_ready !== 2'b10 || bus.t_req_data0 !== 32'd200)
         begin bad++; $display("FAIL lock_next got=%b d0=%0d want=10 d0=200", bus.req_ready, bus.t_req_data0); end
      tick(1'b1);
      bus.req_valid = 2'b00;
   endtask

   task automatic test_full();
      exp_t e;
      logic [N-1:0] oh;
      int guard;
      do_reset();
      bus.t_req_ready = 1'b1;
      bus.req_valid = 2'b11;
      for (int k = 0; k < 5; k++) exp_q.push_back('{id: k % 2, data: (k % 2) ? 32'd202 : 32'd12});
      repeat (4) tick(1'b0);
      @(negedge clk);
      total++; if (bus.t_req_valid !== 1'b0 || bus.req_ready !== 2'b00)
         begin bad++; $display("FAIL full_block got v=%b rdy=%b want v=0 rdy=00", bus.t_req_valid, bus.req_ready); end
      total++; if (dut.count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", dut.count); end
      tick(1'b1);
      bus.t_resp_valid = 1'b1;
      bus.t_resp_data = tgt_q[0];
      @(negedge clk);
      total++; if (bus.t_req_valid !== 1'b0 || bus.t_resp_ready !== 1'b1)
         begin bad++; $display("FAIL full_pop_cycle got req_v=%b resp_rdy=%b want 0/1", bus.t_req_valid, bus.t_resp_ready); end
      tick(1'b1);
      bus.t_resp_valid = 1'b0;
      @(negedge clk);
      total++; if (bus.t_req_valid !== 1'b1 || bus.req_ready !== 2'b01)
         begin bad++; $display("FAIL full_fifth got v=%b rdy=%b want v=1 rdy=01", bus.t_req_valid, bus.req_ready); end
      tick(1'b1);
      bus.req_valid = 2'b00;
      auto_resp = 1'b1;
      guard = 0;
      while (rsp_log.size() < 5 && guard < 20) begin tick(1'b0); guard++; end
      total++; if (acc_log.size() != 5 || rsp_log.size() != 5)
         begin bad++; $display("FAIL full_counts got acc=%0d rsp=%0d want=5/5", acc_log.size(), rsp_log.size()); end
      for (int k = 0; exp_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         oh = '0;
         oh[e.id] = 1'b1;
         total++; if (k >= acc_log.size() || acc_log[k] !== oh)
            begin bad++; $display("FAIL full_grant[%0d] got=%b want=%b", k, (k < acc_log.size()) ? acc_log[k] : 2'bxx, oh); end
         total++; if (k >= rsp_log.size() || rsp_log[k] !== {oh, e.data})
            begin bad++; $display("FAIL full_resp[%0d] got=%h want=%h", k, (k < rsp_log.size()) ? rsp_log[k] : 34'hx, {oh, e.data}); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.t_req_ready = 1'b1;
      bus.req_valid = 2'b10;
      tick(1'b0);
      bus.req_valid = 2'b00;
      bus.t_resp_valid = 1'b1;
      bus.t_resp_data = 32'd202;
      bus.resp_ready = 2'b01;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total++; if (bus.t_resp_ready !== 1'b0 || bus.resp_valid !== 2'b10)
            begin bad++; $display("FAIL bp_hold[%0d] got rdy=%b vld=%b want rdy=0 vld=10", c, bus.t_resp_ready, bus.resp_valid); end
         total++; if (dut.count !== 3'd1) begin bad++; $display("FAIL bp_count[%0d] got=%0d want=1", c, dut.count); end
         tick(1'b1);
      end
      bus.resp_ready = 2'b11;
      @(negedge clk);
      total++; if (bus.t_resp_ready !== 1'b1 || bus.resp_data !== 32'd202)
         begin bad++; $display("FAIL bp_release got rdy=%b data=%0d want rdy=1 data=202", bus.t_resp_ready, bus.resp_data); end
      tick(1'b1);
      bus.t_resp_valid = 1'b0;
      total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL bp_pop got=%0d want=0", dut.count); end
   endtask

   task automatic test_clk_en();
      do_reset();
      clk_en = 1'b0;
      bus.req_valid = 2'b01;
      bus.t_req_ready = 1'b1;
      bus.t_resp_valid = 1'b1;
      @(negedge clk);
      total++; if (bus.t_req_valid !== 1'b0 || bus.req_ready !== 2'b00)
         begin bad++; $display("FAIL clken_req got v=%b rdy=%b want 0/00", bus.t_req_valid, bus.req_ready); end
      tick(1'b1);
      total++; if (dut.count !== 3'd0 || err !== 1'b0)
         begin bad++; $display("FAIL clken_state got count=%0d err=%b want 0/0", dut.count, err); end
      clk_en = 1'b1;
      bus.req_valid = 2'b00;
      bus.t_resp_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.t_req_ready = 1'b1;
      bus.req_valid = 2'b11;
      repeat (2) tick(1'b0);
      bus.req_valid = 2'b00;
      bus.t_req_ready = 1'b0;
      bus.resp_ready = 2'b00;
      bus.t_resp_valid = 1'b1;
      bus.t_resp_data = tgt_q[0];
      total++; if (dut.count !== 3'd2) begin bad++; $display("FAIL mid_outstanding got=%0d want=2", dut.count); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (dut.count !== 3'd0 || bus.resp_valid !== 2'b00)
         begin bad++; $display("FAIL mid_async_clear got count=%0d vld=%b want 0/00", dut.count, bus.resp_valid); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (err !== 1'b0 || bus.t_resp_ready !== 1'b0)
         begin bad++; $display("FAIL mid_stray_pre got err=%b rdy=%b want 0/0", err, bus.t_resp_ready); end
      @(posedge clk);
      #1;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL mid_err_set got=%b want=1", err); end
      bus.t_resp_valid = 1'b0;
      repeat (3) tick(1'b0);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL mid_err_sticky got=%b want=1", err); end
      rst_n = 1'b0;
      #1;
      total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_err_clear got=%b want=0", err); end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_lock();
      test_full();
      test_backpressure();
      test_clk_en();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
